// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce filter.
// The FSM encoding is Gray-like so that the high bit of the state tracks
// the accepted level (IDLE_HI/WAIT_LO) and neighbouring states differ in one bit.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b11,
        WAIT_LO = 2'b10
    } state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_CNT_W           = 16;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Only compiled when DEBOUNCE_SYNC_EN is defined, because that is the only
// build in which debounce_filter instantiates it.
`ifdef DEBOUNCE_SYNC_EN
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the raw bit through the chain; reset clears every stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule
`endif

// File: rtl/debounce_filter.sv
// Debounce filter: turns a raw bouncing input into a clean registered level
// plus a one-cycle 'changed' pulse on every accepted transition.
// Optional feature macro: DEBOUNCE_SYNC_EN. When defined, the input passes
// through a SYNC_STAGES-deep bit_sync chain first; when undefined the input
// must already be synchronous to clk_i and SYNC_STAGES is not used.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic out_o,
    output logic changed_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject parameter sets that would break the counter or the synchroniser.
    if (!(SYNC_STAGES >= 2 && DEBOUNCE_CYCLES >= 2 && DEBOUNCE_CYCLES < (2 ** CNT_W))) begin : gBadParams
        $error("debounce_filter: illegal SYNC_STAGES/DEBOUNCE_CYCLES/CNT_W combination");
    end

    logic       sIn;
    state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       out_q, out_d;
    logic       changed_q, changed_d;

`ifdef DEBOUNCE_SYNC_EN
    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) uSync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (in_i),
        .q_o   (sIn)
    );
`else
    assign sIn = in_i;
`endif

    // State, counter and output registers; reset discards any partial count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE_LO;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            changed_q <= changed_d;
        end
    end

    // Next-state logic: count consecutive opposite samples, restart on any bounce.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        changed_d = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (sIn) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!sIn) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_HI;
                    out_d     = 1'b1;
                    changed_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE_HI: begin
                if (!sIn) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (sIn) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_LO;
                    out_d     = 1'b0;
                    changed_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    assign out_o     = out_q;
    assign changed_o = changed_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Testbench for debounce_filter with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Works with DEBOUNCE_SYNC_EN defined or undefined; the expected latency
// follows the macro.
module tb_debounce_filter;
    import debounce_pkg::*;

    localparam int DC    = 4;
    localparam int SS    = 2;
    localparam int CW    = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT   = SS;
`else
    localparam int LAT   = 0;
`endif

    typedef struct {
        int   cyc;
        logic val;
    } evt_t;

    logic clk_i;
    logic rst_i;
    logic in_i;
    logic out_o;
    logic changed_o;

    int   cyc;
    int   total;
    int   bad;
    bit   monitorOn;
    logic expLevel;
    evt_t expQ[$];

    debounce_filter #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_i      (in_i),
        .out_o     (out_o),
        .changed_o (changed_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Absolute edge counter: after rising edge k, cyc holds k.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
    end

    // Single comparison point shared by stimulus and monitor.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    // Drive a level and hold it; when accept is set, the hand-derived
    // acceptance edge (start + LAT + DC) is queued for the monitor.
    task automatic applyStimulus(input logic v, input int hold, input bit accept);
        evt_t e;
        in_i = v;
        if (accept) begin
            e.cyc = cyc + LAT + DC;
            e.val = v;
            expQ.push_back(e);
        end
        waitEdges(hold);
    endtask

    // Monitor: consumes expected events when the DUT pulses 'changed',
    // flags overdue events and tracks the expected steady level.
    always @(negedge clk_i) begin
        if (monitorOn) begin
            if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                checkOutput("missed_changed", 32'(0), 32'(1));
                expLevel = expQ[0].val;
                void'(expQ.pop_front());
            end
            if (changed_o === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_changed", 32'(1), 32'(0));
                end else begin
                    checkOutput("changed_cycle", 32'(cyc), 32'(expQ[0].cyc));
                    checkOutput("changed_value", 32'(out_o), 32'(expQ[0].val));
                    expLevel = expQ[0].val;
                    void'(expQ.pop_front());
                end
            end
            checkOutput("out_level", 32'(out_o), 32'(expLevel));
        end
    end

    // Directed scenarios.
    initial begin
        evt_t e;
        cyc       = 0;
        total     = 0;
        bad       = 0;
        monitorOn = 1'b0;
        expLevel  = 1'b0;
        in_i      = 1'b0;
        rst_i     = 1'b1;

        waitEdges(3);
        checkOutput("reset_out", 32'(out_o), 32'(0));
        checkOutput("reset_changed", 32'(changed_o), 32'(0));
        checkOutput("reset_state", 32'(dut.state_q), 32'(IDLE_LO));
        checkOutput("reset_cnt", 32'(dut.cnt_q), 32'(0));
        rst_i     = 1'b0;
        monitorOn = 1'b1;

        $display("[TB] rise after reset");
        applyStimulus(1'b1, 10, 1'b1);

        $display("[TB] clean fall");
        applyStimulus(1'b0, 10, 1'b1);

        $display("[TB] short high pulse, rejected");
        applyStimulus(1'b1, 3, 1'b0);
        applyStimulus(1'b0, 10, 1'b0);
        checkOutput("short_pulse_out", 32'(out_o), 32'(0));

        $display("[TB] bounce then settle high");
        applyStimulus(1'b1, 1, 1'b0);
        applyStimulus(1'b0, 1, 1'b0);
        applyStimulus(1'b1, 1, 1'b0);
        applyStimulus(1'b0, 1, 1'b0);
        applyStimulus(1'b1, 12, 1'b1);

        $display("[TB] bounce then settle low");
        applyStimulus(1'b0, 2, 1'b0);
        applyStimulus(1'b1, 1, 1'b0);
        applyStimulus(1'b0, 12, 1'b1);

        $display("[TB] reset during partial count");
        in_i = 1'b1;
        waitEdges(LAT + 2);
        checkOutput("midwait_state", 32'(dut.state_q), 32'(WAIT_HI));
        checkOutput("midwait_cnt", 32'(dut.cnt_q), 32'(2));
        rst_i = 1'b1;
        waitEdges(1);
        checkOutput("rst_out", 32'(out_o), 32'(0));
        checkOutput("rst_changed", 32'(changed_o), 32'(0));
        checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE_LO));
        checkOutput("rst_cnt", 32'(dut.cnt_q), 32'(0));
        rst_i = 1'b0;
        e.cyc = cyc + LAT + DC;
        e.val = 1'b1;
        expQ.push_back(e);
        waitEdges(10);

        checkOutput("final_out", 32'(out_o), 32'(1));
        checkOutput("pending_events", 32'(expQ.size()), 32'(0));
        monitorOn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
